// File: rtl/gray_step_if.sv
// Bus bundle between a Gray-coded counter source and gray_step_checker.
// Macro GRAY_CHK_BIDIR_EN adds the dir_dn status signal.
//   master : source side (drives gray_in/gray_vld, observes status)
//   slave  : checker side (samples gray_in/gray_vld, drives status)
interface gray_step_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
);

  logic [WIDTH-1:0]     gray_in;
  logic                 gray_vld;
  logic [WIDTH-1:0]     bin_out;
  logic                 bin_vld;
  logic                 step_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;
`ifdef GRAY_CHK_BIDIR_EN
  logic                 dir_dn;
`endif

`ifdef GRAY_CHK_BIDIR_EN
  modport master (
    output gray_in, gray_vld,
    input  bin_out, bin_vld, step_err, locked, err_count, dir_dn
  );

  modport slave (
    input  gray_in, gray_vld,
    output bin_out, bin_vld, step_err, locked, err_count, dir_dn
  );
`else
  modport master (
    output gray_in, gray_vld,
    input  bin_out, bin_vld, step_err, locked, err_count
  );

  modport slave (
    input  gray_in, gray_vld,
    output bin_out, bin_vld, step_err, locked, err_count
  );
`endif

endinterface

// File: rtl/gray_step_checker.sv
// Health monitor for a Gray-coded counter/pointer bus.
// Converts each sampled Gray code to binary, checks that it is exactly one
// forward step from the previous sample, and reports lock status plus a
// saturating count of errors seen while locked.
//
// Optional feature: define GRAY_CHK_BIDIR_EN to also accept -1 steps as
// good and to expose the direction of the last good step on bus.dir_dn.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   bus.gray_in     Gray code from the upstream counter
//   bus.gray_vld    sample strobe
//   bus.bin_out     registered binary value of the last sample
//   bus.bin_vld     one-cycle pulse, status outputs updated this cycle
//   bus.step_err    one-cycle pulse, last sample was a bad step
//   bus.locked      high while tracking a valid sequence
//   bus.err_count   saturating count of errors seen while locked
//   bus.dir_dn      (GRAY_CHK_BIDIR_EN only) 1 = last good step was -1
module gray_step_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  gray_step_if.slave  bus
);

  // LOCK_COUNT is limited to 1..15, so four bits always suffice.
  localparam int unsigned GOOD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [GOOD_CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0]       prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0]       bin_out_q, bin_out_d;
  logic                   bin_vld_q, bin_vld_d;
  logic                   step_err_q, step_err_d;
  logic                   locked_q, locked_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
`ifdef GRAY_CHK_BIDIR_EN
  logic                   dir_dn_q, dir_dn_d;
`endif

  logic [WIDTH-1:0]       bin_c;
  logic [WIDTH-1:0]       prev_inc_c;
  logic                   is_inc_c;
  logic                   is_dec_c;
  logic                   is_good_c;
  logic                   is_stall_c;
  logic                   is_bad_c;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_c[i] = ^(bus.gray_in >> i);
    end
  end

  // Step classification against the previous sample (modulo wrap is implicit).
  always_comb begin
    prev_inc_c = prev_bin_q + WIDTH'(1);
    is_inc_c   = (bin_c == prev_inc_c);
    is_stall_c = (bin_c == prev_bin_q);
`ifdef GRAY_CHK_BIDIR_EN
    is_dec_c   = (bin_c == (prev_bin_q - WIDTH'(1)));
`else
    is_dec_c   = 1'b0;
`endif
    is_good_c  = is_inc_c | is_dec_c;
    is_bad_c   = ~is_good_c & ~is_stall_c;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      good_cnt_q  <= '0;
      prev_bin_q  <= '0;
      bin_out_q   <= '0;
      bin_vld_q   <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
`ifdef GRAY_CHK_BIDIR_EN
      dir_dn_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      prev_bin_q  <= prev_bin_d;
      bin_out_q   <= bin_out_d;
      bin_vld_q   <= bin_vld_d;
      step_err_q  <= step_err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
`ifdef GRAY_CHK_BIDIR_EN
      dir_dn_q    <= dir_dn_d;
`endif
    end
  end

  // Next-state logic: acquisition counting and lock/unlock transitions.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    if (bus.gray_vld) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
        end
        ST_ACQ: begin
          if (is_good_c) begin
            good_cnt_d = good_cnt_q + GOOD_CNT_W'(1);
            if (good_cnt_q == GOOD_CNT_W'(LOCK_COUNT - 1)) begin
              state_d = ST_LOCKED;
            end
          end else if (is_bad_c) begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (is_bad_c) begin
            state_d    = ST_ACQ;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic: next values of the registered status outputs.
  always_comb begin
    bin_vld_d   = bus.gray_vld;
    bin_out_d   = bin_out_q;
    prev_bin_d  = prev_bin_q;
    step_err_d  = 1'b0;
    err_count_d = err_count_q;
    locked_d    = (state_d == ST_LOCKED);
`ifdef GRAY_CHK_BIDIR_EN
    dir_dn_d    = dir_dn_q;
`endif
    if (bus.gray_vld) begin
      bin_out_d  = bin_c;
      // Every sample, good or bad, becomes the reference for the next one.
      prev_bin_d = bin_c;
      if (state_q != ST_IDLE) begin
        step_err_d = is_bad_c;
`ifdef GRAY_CHK_BIDIR_EN
        if (is_good_c) begin
          dir_dn_d = is_dec_c;
        end
`endif
      end
      // Only errors that break an established lock are counted.
      if ((state_q == ST_LOCKED) && is_bad_c && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.bin_vld   = bin_vld_q;
  assign bus.step_err  = step_err_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = err_count_q;
`ifdef GRAY_CHK_BIDIR_EN
  assign bus.dir_dn    = dir_dn_q;
`endif

endmodule

// File: tb/tb_gray_step_checker.sv
// Scoreboard bench for gray_step_checker (WIDTH=8, LOCK_COUNT=4, ERR_CNT_W=2).
module tb_gray_step_checker;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned ERR_CNT_W  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gray_step_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  gray_step_checker #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] bin;
    logic       err;
    logic       lock;
    logic [1:0] cnt;
    logic       dn;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare whatever the DUT produced at the last rising edge.
  task automatic check_out();
    exp_t e;
    chk("bin_vld", 32'(bus.bin_vld), 32'(sb_q.size() != 0));
    if (bus.bin_vld && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("bin_out",   32'(bus.bin_out),   32'(e.bin));
      chk("step_err",  32'(bus.step_err),  32'(e.err));
      chk("locked",    32'(bus.locked),    32'(e.lock));
      chk("err_count", 32'(bus.err_count), 32'(e.cnt));
`ifdef GRAY_CHK_BIDIR_EN
      chk("dir_dn",    32'(bus.dir_dn),    32'(e.dn));
`endif
    end else begin
      chk("step_err_idle", 32'(bus.step_err), 32'd0);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bin_out"},   32'(bus.bin_out),   32'd0);
    chk({tag, "_bin_vld"},   32'(bus.bin_vld),   32'd0);
    chk({tag, "_step_err"},  32'(bus.step_err),  32'd0);
    chk({tag, "_locked"},    32'(bus.locked),    32'd0);
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
`ifdef GRAY_CHK_BIDIR_EN
    chk({tag, "_dir_dn"},    32'(bus.dir_dn),    32'd0);
`endif
  endtask

  // One cycle: check last result, then drive a sample given in binary.
  task automatic step(input logic vld, input logic [7:0] b, input logic e_err,
                      input logic e_lock, input logic [1:0] e_cnt, input logic e_dn);
    exp_t e;
    @(negedge clk);
    check_out();
    rst          = 1'b0;
    bus.gray_vld = vld;
    bus.gray_in  = b ^ (b >> 1);
    if (vld) begin
      e.bin  = b;
      e.err  = e_err;
      e.lock = e_lock;
      e.cnt  = e_cnt;
      e.dn   = e_dn;
      sb_q.push_back(e);
    end
  endtask

  // Reset for one cycle, optionally with a sample strobe in the same cycle.
  task automatic reset_cycle(input logic vld, input string tag);
    @(negedge clk);
    check_out();
    rst          = 1'b1;
    bus.gray_vld = vld;
    bus.gray_in  = 8'h33;
    @(negedge clk);
    check_out();
    check_zero(tag);
    rst          = 1'b0;
    bus.gray_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] base;
    logic [1:0] sat;
    rst          = 1'b1;
    bus.gray_vld = 1'b0;
    bus.gray_in  = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");

    // Acquire lock from 0, with an idle gap in the middle.
    step(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b1, 2'd0, 1'b0);

    // Bad step while locked, then re-acquire from the new value.
    step(1'b1, 8'h07, 1'b1, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'h08, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b1, 2'd1, 1'b0);

    // Jump to 0xF9, relock at 0xFD, then step/stall through the wrap.
    step(1'b1, 8'hF9, 1'b1, 1'b0, 2'd2, 1'b0);
    step(1'b1, 8'hFA, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b1, 8'hFB, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b1, 8'hFC, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b1, 8'hFD, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'hFE, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0);

    // Reset wins over a simultaneous sample and clears all history.
    reset_cycle(1'b1, "midrst");
    step(1'b1, 8'h55, 1'b0, 1'b0, 2'd0, 1'b0);
    // Bad step during acquisition pulses step_err but is not counted.
    step(1'b1, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h14, 1'b0, 1'b1, 2'd0, 1'b0);

    // Four lock-break events: 2-bit error counter reads 1,2,3,3.
    for (int k = 1; k <= 4; k++) begin
      base = 8'(k * 32);
      sat  = (k < 3) ? 2'(k) : 2'd3;
      step(1'b1, base, 1'b1, 1'b0, sat, 1'b0);
      if (k < 4) begin
        for (int i = 1; i <= 3; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, sat, 1'b0);
        step(1'b1, base + 8'd4, 1'b0, 1'b1, sat, 1'b0);
      end
    end
    // Stall during acquisition neither counts nor resets progress.
    step(1'b1, 8'h80, 1'b0, 1'b0, 2'd3, 1'b0);
    step(1'b1, 8'h81, 1'b0, 1'b0, 2'd3, 1'b0);
    step(1'b1, 8'h82, 1'b0, 1'b0, 2'd3, 1'b0);
    step(1'b1, 8'h83, 1'b0, 1'b0, 2'd3, 1'b0);
    step(1'b1, 8'h84, 1'b0, 1'b1, 2'd3, 1'b0);

    // Counting down: good only with the bidirectional option.
    reset_cycle(1'b0, "rst2");
`ifdef GRAY_CHK_BIDIR_EN
    step(1'b1, 8'h04, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
`else
    step(1'b1, 8'h04, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
